config_streamer: RTL and testbench

CONFIG_STREAMER -- requirements
Module: config_streamer

---
 rtl/cfg_stream_pkg.sv | 19 +
 rtl/cfg_rb_deser.sv | 53 +++++
 rtl/config_streamer.sv | 127 ++++++++++++
 tb/tb_config_streamer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_stream_pkg.sv
// Shared types and constants for the configuration-chain streamer.
package cfg_stream_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_t;

    // Smaller of two unsigned quantities; sizes the bit count of a word load.
    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_rb_deser.sv
// Readback deserializer: packs chain-tail bits LSB first into words.
module cfg_rb_deser
    import cfg_stream_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset_n,
    input  logic              clr,
    input  logic              cap_en,
    input  logic              cap_bit,
    input  logic              last_bit,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid
);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_nx;
    logic [LEN_W-1:0]  rbcnt;
    logic              word_full;

    assign acc_nx    = acc | (WORD_W'(cap_bit) << rbcnt);
    assign word_full = (rbcnt == LEN_W'(WORD_W - 1));

    // Capture one tail bit per shift; publish on a full word or on the stream's last bit.
    always_ff @(posedge Config_Clock or negedge Config_Reset_n) begin
        if (!Config_Reset_n) begin
            acc      <= '0;
            rbcnt    <= '0;
            rb_word  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clr) begin
                acc     <= '0;
                rbcnt   <= '0;
                rb_word <= '0;
            end else if (cap_en) begin
                if (word_full || last_bit) begin
                    rb_word  <= acc_nx;
                    rb_valid <= 1'b1;
                    acc      <= '0;
                    rbcnt    <= '0;
                end else begin
                    acc   <= acc_nx;
                    rbcnt <= rbcnt + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/config_streamer.sv
// Streams host configuration words serially into a scan chain and reads the
// chain tail back into words.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; chain_len sampled on start
//   ST_LOAD  | word_ready high, waiting for the next host word
//   ST_SHIFT | one bit per cycle onto ConfigOut with shift_en high
//   ST_DONE  | one-cycle done pulse, then back to idle
module config_streamer
    import cfg_stream_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ConfigOut,
    output logic              shift_en,
    input  logic              ChainTail,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    cfg_state_t        state, state_nx;
    logic [WORD_W-1:0] sreg, sreg_nx;
    logic [LEN_W-1:0]  bitcnt, bitcnt_nx;
    logic [LEN_W-1:0]  remaining, rem_nx;
    logic              last_bit;

    assign busy       = (state != ST_IDLE);
    assign word_ready = (state == ST_LOAD) && !abort;
    assign last_bit   = (state == ST_SHIFT) && (remaining == LEN_W'(1));

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_nx  = state;
        sreg_nx   = sreg;
        bitcnt_nx = bitcnt;
        rem_nx    = remaining;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (chain_len != '0) begin
                        rem_nx   = chain_len;
                        state_nx = ST_LOAD;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid && word_ready) begin
                    sreg_nx   = word_data;
                    bitcnt_nx = LEN_W'(min_u(32'(remaining), WORD_W));
                    state_nx  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_nx   = sreg >> 1;
                bitcnt_nx = (bitcnt != '0) ? bitcnt - LEN_W'(1) : '0;
                rem_nx    = (remaining != '0) ? remaining - LEN_W'(1) : '0;
                if (remaining <= LEN_W'(1)) begin
                    state_nx = ST_DONE;
                end else if (bitcnt <= LEN_W'(1)) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_nx  = ST_IDLE;
            sreg_nx   = '0;
            bitcnt_nx = '0;
            rem_nx    = '0;
        end
    end

    // State register plus registered chain strobes so the chain sees clean levels.
    always_ff @(posedge Config_Clock or negedge Config_Reset_n) begin
        if (!Config_Reset_n) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bitcnt    <= '0;
            remaining <= '0;
            shift_en  <= 1'b0;
            ConfigOut <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            sreg      <= sreg_nx;
            bitcnt    <= bitcnt_nx;
            remaining <= rem_nx;
            shift_en  <= (state_nx == ST_SHIFT);
            ConfigOut <= (state_nx == ST_SHIFT) && sreg_nx[0];
            done      <= (state_nx == ST_DONE);
        end
    end

    cfg_rb_deser #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_rb_deser (
        .Config_Clock   (Config_Clock),
        .Config_Reset_n (Config_Reset_n),
        .clr            (abort),
        .cap_en         (shift_en),
        .cap_bit        (ChainTail),
        .last_bit       (last_bit),
        .rb_word        (rb_word),
        .rb_valid       (rb_valid)
    );

endmodule

// File: tb/tb_config_streamer.sv
// Directed bench for config_streamer with a 40-cell loopback chain model.
module tb_config_streamer;

    localparam int WW = 32;
    localparam int LW = 16;

    logic          Config_Clock   = 1'b0;
    logic          Config_Reset_n = 1'b0;
    logic          start          = 1'b0;
    logic          abort          = 1'b0;
    logic          word_valid     = 1'b0;
    logic [LW-1:0] chain_len      = '0;
    logic [WW-1:0] word_data      = '0;
    logic          ChainTail;
    logic          word_ready, ConfigOut, shift_en, rb_valid, busy, done;
    logic [WW-1:0] rb_word;

    int n_pass  = 0;
    int n_total = 0;

    config_streamer #(.WORD_W(WW), .LEN_W(LW)) dut (
        .Config_Clock   (Config_Clock),
        .Config_Reset_n (Config_Reset_n),
        .start          (start),
        .chain_len      (chain_len),
        .abort          (abort),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_ready     (word_ready),
        .ConfigOut      (ConfigOut),
        .shift_en       (shift_en),
        .ChainTail      (ChainTail),
        .rb_word        (rb_word),
        .rb_valid       (rb_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 Config_Clock = ~Config_Clock;

    // 40-cell chain: head takes ConfigOut, tail feeds ChainTail.
    logic [39:0] chain;
    logic        chain_clr = 1'b1;
    always @(posedge Config_Clock or posedge chain_clr) begin
        if (chain_clr) chain <= '0;
        else if (shift_en) chain <= {chain[38:0], ConfigOut};
    end
    assign ChainTail = chain[39];

    // Cumulative logs of shifted bits, readback words and done pulses.
    logic          mon_bits [0:4095];
    int            mon_n  = 0;
    logic [WW-1:0] rb_log [0:255];
    int            rb_n   = 0;
    int            done_n = 0;
    always @(negedge Config_Clock) begin
        if (shift_en === 1'b1 && mon_n < 4096) begin
            mon_bits[mon_n] <= ConfigOut;
            mon_n <= mon_n + 1;
        end
        if (rb_valid === 1'b1 && rb_n < 256) begin
            rb_log[rb_n] <= rb_word;
            rb_n <= rb_n + 1;
        end
        if (done === 1'b1) done_n <= done_n + 1;
    end

    function automatic logic [63:0] bits_since(input int base, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n && i < 64; i++) v[i] = mon_bits[base + i];
        return v;
    endfunction

    task automatic cyc();
        @(posedge Config_Clock);
        #1;
    endtask

    task automatic run_stream(input int len, input int nw, input logic [WW-1:0] w0,
                              input logic [WW-1:0] w1, input int stall,
                              output int ok, output int stall_bad);
        int t;
        ok = 1;
        stall_bad = 0;
        cyc();
        chain_len = LW'(len);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < nw; k++) begin
            t = 0;
            while (word_ready !== 1'b1 && t < 200) begin cyc(); t++; end
            if (t >= 200) ok = 0;
            if (k == 1 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    if (shift_en !== 1'b0 || word_ready !== 1'b1) stall_bad++;
                    cyc();
                end
            end
            word_data = (k == 0) ? w0 : w1;
            word_valid = 1'b1;
            cyc();
            word_valid = 1'b0;
        end
        t = 0;
        while (done !== 1'b1 && t < 400) begin cyc(); t++; end
        if (t >= 400) ok = 0;
    endtask

    task automatic test_reset();
        Config_Reset_n = 1'b0;
        start = 1'b1;
        chain_len = LW'(8);
        repeat (3) cyc();
        n_total++;
        if ({shift_en, ConfigOut, word_ready, rb_valid, busy, done} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                     {shift_en, ConfigOut, word_ready, rb_valid, busy, done});
        else n_pass++;
        n_total++;
        if (rb_word !== '0) $display("FAIL reset_rb_word: got %h want 0", rb_word);
        else n_pass++;
        start = 1'b0;
        @(negedge Config_Clock);
        Config_Reset_n = 1'b1;
        chain_clr = 1'b0;
        repeat (2) cyc();
        n_total++;
        if (busy !== 1'b0 || word_ready !== 1'b0)
            $display("FAIL reset_release_idle: busy=%b ready=%b want 0 0", busy, word_ready);
        else n_pass++;
    endtask

    task automatic test_single_word();
        int mb, db, rbb, ok, sb;
        mb = mon_n; db = done_n; rbb = rb_n;
        run_stream(8, 1, 32'h0000_00A5, 32'h0, 0, ok, sb);
        n_total++;
        if (ok != 1) $display("FAIL single_timeout: got ok=%0d want 1", ok);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy_in_done: got %b want 1", busy);
        else n_pass++;
        cyc();
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL single_busy_after_done: busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        repeat (3) cyc();
        n_total++;
        if (mon_n - mb != 8) $display("FAIL single_shift_count: got %0d want 8", mon_n - mb);
        else n_pass++;
        n_total++;
        if (bits_since(mb, 8) !== 64'hA5)
            $display("FAIL single_sequence: got %h want a5", bits_since(mb, 8));
        else n_pass++;
        n_total++;
        if (done_n - db != 1) $display("FAIL single_done_count: got %0d want 1", done_n - db);
        else n_pass++;
        n_total++;
        if (rb_n - rbb != 1) $display("FAIL single_rb_count: got %0d want 1", rb_n - rbb);
        else n_pass++;
    endtask

    task automatic test_two_words();
        int mb, db, rbb, ok, sb;
        logic [63:0] v;
        chain_clr = 1'b1; #1; chain_clr = 1'b0;
        mb = mon_n; db = done_n; rbb = rb_n;
        run_stream(40, 2, 32'hFFFF_FFFF, 32'h0000_00F3, 0, ok, sb);
        repeat (4) cyc();
        v = bits_since(mb, 40);
        n_total++;
        if (ok != 1) $display("FAIL two_timeout: got ok=%0d want 1", ok);
        else n_pass++;
        n_total++;
        if (mon_n - mb != 40) $display("FAIL two_shift_count: got %0d want 40", mon_n - mb);
        else n_pass++;
        n_total++;
        if (v[39:0] !== 40'hF3_FFFF_FFFF)
            $display("FAIL two_sequence: got %h want f3ffffffff", v[39:0]);
        else n_pass++;
        n_total++;
        if (done_n - db != 1) $display("FAIL two_done_count: got %0d want 1", done_n - db);
        else n_pass++;
        n_total++;
        if (rb_n - rbb != 2 || rb_log[rbb] !== 32'h0 || rb_log[rbb+1] !== 32'h0)
            $display("FAIL two_rb_empty_chain: got n=%0d %h %h want n=2 0 0",
                     rb_n - rbb, rb_log[rbb], rb_log[rbb+1]);
        else n_pass++;
    endtask

    task automatic test_stall();
        int mb, db, rbb, ok, sb;
        logic [63:0] v;
        mb = mon_n; db = done_n; rbb = rb_n;
        run_stream(40, 2, 32'hFFFF_FFFF, 32'h0000_00F3, 5, ok, sb);
        repeat (4) cyc();
        v = bits_since(mb, 40);
        n_total++;
        if (ok != 1) $display("FAIL stall_timeout: got ok=%0d want 1", ok);
        else n_pass++;
        n_total++;
        if (sb != 0) $display("FAIL stall_hold: got %0d bad stall cycles want 0", sb);
        else n_pass++;
        n_total++;
        if (mon_n - mb != 40 || v[39:0] !== 40'hF3_FFFF_FFFF)
            $display("FAIL stall_sequence: got n=%0d %h want n=40 f3ffffffff", mon_n - mb, v[39:0]);
        else n_pass++;
        n_total++;
        if (done_n - db != 1) $display("FAIL stall_done_count: got %0d want 1", done_n - db);
        else n_pass++;
        n_total++;
        if (rb_n - rbb != 2 || rb_log[rbb] !== 32'hFFFF_FFFF || rb_log[rbb+1] !== 32'h0000_00F3)
            $display("FAIL stall_readback: got n=%0d %h %h want n=2 ffffffff 000000f3",
                     rb_n - rbb, rb_log[rbb], rb_log[rbb+1]);
        else n_pass++;
    endtask

    task automatic test_loopback();
        int mb, rbb, ok, sb;
        logic [63:0] v;
        mb = mon_n; rbb = rb_n;
        run_stream(40, 2, 32'h0, 32'h0, 0, ok, sb);
        repeat (4) cyc();
        v = bits_since(mb, 40);
        n_total++;
        if (ok != 1 || mon_n - mb != 40 || v[39:0] !== 40'h0)
            $display("FAIL loop_zero_stream: got ok=%0d n=%0d %h want 1 40 0", ok, mon_n - mb, v[39:0]);
        else n_pass++;
        n_total++;
        if (rb_n - rbb != 2) $display("FAIL loop_rb_count: got %0d want 2", rb_n - rbb);
        else n_pass++;
        n_total++;
        if (rb_log[rbb] !== 32'hFFFF_FFFF) $display("FAIL loop_rb_word0: got %h want ffffffff", rb_log[rbb]);
        else n_pass++;
        n_total++;
        if (rb_log[rbb+1] !== 32'h0000_00F3) $display("FAIL loop_rb_partial: got %h want 000000f3", rb_log[rbb+1]);
        else n_pass++;
        n_total++;
        if (rb_word !== 32'h0000_00F3) $display("FAIL loop_rb_hold: got %h want 000000f3", rb_word);
        else n_pass++;
    endtask

    task automatic test_abort();
        int mb, db, ok, sb;
        logic [63:0] v;
        mb = mon_n; db = done_n;
        cyc();
        chain_len = LW'(40);
        start = 1'b1;
        cyc();
        start = 1'b0;
        word_data = 32'h1234_5678;
        word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        repeat (10) @(posedge Config_Clock);
        #1;
        n_total++;
        if (shift_en !== 1'b1) $display("FAIL abort_pre_shift: got %b want 1", shift_en);
        else n_pass++;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        n_total++;
        if ({shift_en, busy, word_ready} !== 3'b000)
            $display("FAIL abort_next_cycle: got shift/busy/ready=%b want 000", {shift_en, busy, word_ready});
        else n_pass++;
        n_total++;
        if (rb_word !== 32'h0) $display("FAIL abort_rb_cleared: got %h want 0", rb_word);
        else n_pass++;
        repeat (3) cyc();
        n_total++;
        if (done_n != db) $display("FAIL abort_no_done: got %0d pulses want 0", done_n - db);
        else n_pass++;
        n_total++;
        if (mon_n - mb != 11) $display("FAIL abort_shift_count: got %0d want 11", mon_n - mb);
        else n_pass++;

        // abort while waiting for a word: ready must drop and the word is not taken
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        word_data = 32'hDEAD_BEEF;
        word_valid = 1'b1;
        abort = 1'b1;
        #1;
        n_total++;
        if (word_ready !== 1'b0) $display("FAIL abort_load_ready: got %b want 0", word_ready);
        else n_pass++;
        cyc();
        abort = 1'b0;
        word_valid = 1'b0;
        cyc();
        n_total++;
        if (busy !== 1'b0 || shift_en !== 1'b0)
            $display("FAIL abort_load_idle: busy=%b shift=%b want 0 0", busy, shift_en);
        else n_pass++;

        mb = mon_n; db = done_n;
        run_stream(40, 2, 32'h1234_5678, 32'h0000_00AB, 0, ok, sb);
        repeat (4) cyc();
        v = bits_since(mb, 40);
        n_total++;
        if (ok != 1 || mon_n - mb != 40 || v[39:0] !== 40'hAB_1234_5678)
            $display("FAIL abort_restart: got ok=%0d n=%0d %h want 1 40 ab12345678", ok, mon_n - mb, v[39:0]);
        else n_pass++;
        n_total++;
        if (done_n - db != 1) $display("FAIL abort_restart_done: got %0d want 1", done_n - db);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int mb;
        mb = mon_n;
        cyc();
        chain_len = LW'(40);
        start = 1'b1;
        cyc();
        start = 1'b0;
        word_data = 32'hFFFF_FFFF;
        word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        repeat (5) @(posedge Config_Clock);
        #1;
        n_total++;
        if (shift_en !== 1'b1 || ConfigOut !== 1'b1)
            $display("FAIL rstmid_pre: shift=%b out=%b want 1 1", shift_en, ConfigOut);
        else n_pass++;
        #1;
        Config_Reset_n = 1'b0;
        #1;
        n_total++;
        if ({shift_en, ConfigOut, word_ready, rb_valid, busy, done} !== 6'b0 || rb_word !== '0)
            $display("FAIL rstmid_outputs: got %b rb=%h want 000000 0",
                     {shift_en, ConfigOut, word_ready, rb_valid, busy, done}, rb_word);
        else n_pass++;
        @(negedge Config_Clock);
        Config_Reset_n = 1'b1;
        repeat (5) cyc();
        n_total++;
        if (mon_n - mb != 5 || busy !== 1'b0)
            $display("FAIL rstmid_no_replay: got shifts=%0d busy=%b want 5 0", mon_n - mb, busy);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        int mb, db, ok, sb;
        mb = mon_n; db = done_n;
        run_stream(0, 0, 32'h0, 32'h0, 0, ok, sb);
        n_total++;
        if (ok != 1 || done !== 1'b1) $display("FAIL zero_done: got ok=%0d done=%b want 1 1", ok, done);
        else n_pass++;
        cyc();
        n_total++;
        if (busy !== 1'b0) $display("FAIL zero_busy_after: got %b want 0", busy);
        else n_pass++;
        repeat (3) cyc();
        n_total++;
        if (mon_n - mb != 0 || done_n - db != 1)
            $display("FAIL zero_counts: got shifts=%0d dones=%0d want 0 1", mon_n - mb, done_n - db);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_stall();
        test_loopback();
        test_abort();
        test_reset_mid();
        test_zero_len();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
